arrow_menu_ctrl: RTL and testbench
==================================

ARROW_MENU_CTRL -- requirements
Module: arrow_menu_ctrl

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- NUM_ITEMS, 4, number of selectable menu rows (2..16).
- BASE_X, 10'd200, arrow pixel column for all rows.
- BASE_Y, 10'd150, arrow pixel row for item 0.
- ROW_STEP, 10'd40, vertical pixel pitch between items.
- DEB_FRAMES, 3, consecutive frame_tick samples high required to accept a press (1..15).
- BLINK_FRAMES, 30, frame_ticks per arrow blink half-period (1..255).
REQ-002 IDX_W SHALL be max(1, clog2(NUM_ITEMS)).
REQ-003 Elaboration SHALL fail if BASE_Y + (NUM_ITEMS-1)*ROW_STEP > 1023.
REQ-004 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock (pixel clock domain).
- rst, in, 1, synchronous active-high reset.
- frame_tick, in, 1, one-cycle pulse at vertical-blank start.
- btn_up, in, 1, up button, already synchronized to clk, active-high.
- btn_down, in, 1, down button, same conditioning.
- btn_sel, in, 1, select button, same conditioning.
- pos_x, out, 10, arrow sprite origin X for the arrow renderer.
- pos_y, out, 10, arrow sprite origin Y for the arrow renderer.
- arrow_en, out, 1, arrow visibility gate (ANDed downstream with the renderer's visible output).
- index, out, IDX_W, currently highlighted item.
- sel_valid, out, 1, selection offered.
- sel_index, out, IDX_W, item being offered; stable while sel_valid=1.
- sel_ready, in, 1, consumer accepts the selection.

Function
REQ-005 One debounce counter per button (4-bit, saturating at DEB_FRAMES) SHALL update only on cycles with frame_tick=1: button high -> increment; button low -> clear to 0.
REQ-006 A press event SHALL be generated for exactly the one frame_tick cycle in which the button's counter goes from DEB_FRAMES-1 to DEB_FRAMES; holding a button SHALL produce no further events (no auto-repeat).
REQ-007 The FSM SHALL have states NAV, CONFIRM, LOCK; reset state NAV.
REQ-008 In NAV, a sel event SHALL take priority: sel_index<=index, sel_valid<=1, go to CONFIRM, no move that cycle.
REQ-009 In NAV without sel: up only -> index decrements, 0 wraps to NUM_ITEMS-1; down only -> index increments, NUM_ITEMS-1 wraps to 0; up and down together -> no change.
REQ-010 pos_x SHALL be BASE_X constantly; pos_y SHALL be registered BASE_Y + index*ROW_STEP (10-bit), updated in the same clock edge as index, so pos_x/pos_y change only on the cycle following a frame_tick (tear-free).
REQ-011 In CONFIRM, sel_valid and sel_index SHALL hold until a cycle with sel_valid=1 and sel_ready=1; sel_valid SHALL drop on the following cycle, and the FSM SHALL enter LOCK. Button events SHALL be ignored in CONFIRM.
REQ-012 sel_ready while sel_valid=0 SHALL have no effect.
REQ-013 In LOCK, the FSM SHALL return to NAV on the first frame_tick at which all three debounce counters are 0 after that tick's update; button events during LOCK SHALL be ignored.
REQ-014 Blink, NAV only: an 8-bit frame counter SHALL increment per frame_tick; on reaching BLINK_FRAMES-1 it SHALL clear and arrow_en SHALL toggle.
REQ-015 Any index change SHALL clear the blink counter and force arrow_en=1 on the same clock edge.
REQ-016 In CONFIRM and LOCK, arrow_en SHALL be 1 and the blink counter SHALL be held at 0.
REQ-017 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-018 While rst=1 at a clk edge, the block SHALL apply index=0, pos_x=BASE_X, pos_y=BASE_Y, arrow_en=1, sel_valid=0, sel_index=0, state NAV, and all debounce and blink counters cleared.
REQ-019 Reset SHALL override any other event in the same cycle, including an in-flight CONFIRM; sel_valid SHALL be 0 on the cycle after rst is sampled.

Verification
REQ-020 The verification bench SHALL cover the following directed scenarios, all with default parameters:
- After reset, btn_down held for 3 frame_ticks -> index=1, pos_y=190 one cycle after the 3rd tick; holding for 10 more ticks -> still index=1.
- From index=0, one up press -> index=3, pos_y=270; then one down press -> index=0, pos_y=150.
- btn_up and btn_down pressed on the same tick -> index unchanged, blink counter not cleared.
- btn_sel press at index=2 with sel_ready=0 for 5 cycles, then 1 -> sel_valid=1, sel_index=2 held through the 5 cycles, sel_valid=0 the cycle after the handshake, state LOCK; then a down press while btn_sel is still held -> ignored.
- Idle in NAV for 60 frame_ticks -> arrow_en toggles at tick 30 and tick 60; a move at tick 45 -> arrow_en=1 and the blink phase restarts.
- rst asserted while sel_valid=1 -> sel_valid=0, index=0, pos_y=150 on the next cycle; no handshake is recorded.

Source files
------------

// File: rtl/arrow_menu_ctrl.sv
// Arrow-cursor menu controller: debounced up/down/select navigation, a blinking
// arrow, and a valid/ready selection handshake. All outputs are registered and
// only move on frame_tick cycles, so the renderer never sees a mid-frame jump.

// Per-button debounce: counts consecutive high frame_tick samples (saturating)
// and pulses press exactly on the sample that reaches DEB_FRAMES.
module arrow_menu_deb #(
   parameter int DEB_FRAMES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_tick,
   input  logic btn,
   output logic press,
   output logic zero_nxt
);
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;

   // next counter value: only frame_tick samples count, release clears
   always_comb begin
      cnt_nxt = cnt;
      if (frame_tick) begin
         if (!btn)
            cnt_nxt = '0;
         else if (cnt != 4'(DEB_FRAMES))
            cnt_nxt = cnt + 4'd1;
      end
   end

   // counter register
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_nxt;
   end

   assign press    = (cnt_nxt == 4'(DEB_FRAMES)) && (cnt != 4'(DEB_FRAMES));
   assign zero_nxt = (cnt_nxt == 4'd0);
endmodule

module arrow_menu_ctrl #(
   parameter int         NUM_ITEMS    = 4,
   parameter logic [9:0] BASE_X       = 10'd200,
   parameter logic [9:0] BASE_Y       = 10'd150,
   parameter logic [9:0] ROW_STEP     = 10'd40,
   parameter int         DEB_FRAMES   = 3,
   parameter int         BLINK_FRAMES = 30,
   localparam int        IDX_W        = ($clog2(NUM_ITEMS) < 1) ? 1 : $clog2(NUM_ITEMS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_tick,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_sel,
   output logic [9:0]       pos_x,
   output logic [9:0]       pos_y,
   output logic             arrow_en,
   output logic [IDX_W-1:0] index,
   output logic             sel_valid,
   output logic [IDX_W-1:0] sel_index,
   input  logic             sel_ready
);
   // the last row must still fit on a 10-bit pixel coordinate
   if (int'(BASE_Y) + (NUM_ITEMS - 1) * int'(ROW_STEP) > 1023) begin : g_bad_geom
      $error("arrow_menu_ctrl: last row exceeds 10-bit pos_y");
   end

   typedef enum logic [1:0] {NAV, CONFIRM, LOCK} state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ITEMS - 1);

   state_t           state;
   logic [7:0]       blink;
   logic [2:0]       btns;
   logic [2:0]       press;
   logic [2:0]       zero_nxt;
   logic             ev_up, ev_down, ev_sel, mv;
   logic [IDX_W-1:0] idx_nxt;

   assign btns = {btn_sel, btn_down, btn_up};

   for (genvar b = 0; b < 3; b++) begin : g_deb
      arrow_menu_deb #(.DEB_FRAMES(DEB_FRAMES)) u_deb (
         .clk       (clk),
         .rst       (rst),
         .frame_tick(frame_tick),
         .btn       (btns[b]),
         .press     (press[b]),
         .zero_nxt  (zero_nxt[b])
      );
   end

   assign ev_up   = press[0];
   assign ev_down = press[1];
   assign ev_sel  = press[2];
   assign mv      = ev_up ^ ev_down;

   // wrap-around neighbour of the current row; simultaneous up+down cancels
   always_comb begin
      idx_nxt = index;
      if (ev_up && !ev_down)
         idx_nxt = (index == '0) ? LAST : index - IDX_W'(1);
      else if (ev_down && !ev_up)
         idx_nxt = (index == LAST) ? '0 : index + IDX_W'(1);
   end

   // menu FSM with registered cursor position, blink and selection outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= NAV;
         index     <= '0;
         pos_x     <= BASE_X;
         pos_y     <= BASE_Y;
         arrow_en  <= 1'b1;
         sel_valid <= 1'b0;
         sel_index <= '0;
         blink     <= '0;
      end else begin
         pos_x <= BASE_X;
         unique case (state)
            NAV: begin
               if (ev_sel) begin
                  sel_index <= index;
                  sel_valid <= 1'b1;
                  arrow_en  <= 1'b1;
                  blink     <= '0;
                  state     <= CONFIRM;
               end else if (mv) begin
                  index    <= idx_nxt;
                  pos_y    <= BASE_Y + 10'(idx_nxt) * ROW_STEP;
                  arrow_en <= 1'b1;
                  blink    <= '0;
               end else if (frame_tick) begin
                  if (blink == 8'(BLINK_FRAMES - 1)) begin
                     blink    <= '0;
                     arrow_en <= ~arrow_en;
                  end else begin
                     blink <= blink + 8'd1;
                  end
               end
            end
            CONFIRM: begin
               arrow_en <= 1'b1;
               blink    <= '0;
               if (sel_valid && sel_ready) begin
                  sel_valid <= 1'b0;
                  state     <= LOCK;
               end
            end
            LOCK: begin
               arrow_en <= 1'b1;
               blink    <= '0;
               // wait until every button has been released before navigating again
               if (frame_tick && (&zero_nxt))
                  state <= NAV;
            end
            default: state <= NAV;
         endcase
      end
   end
endmodule

// File: tb/tb_arrow_menu_ctrl.sv
// Bench for arrow_menu_ctrl: table of navigation steps, directed multi-cycle
// sequences, and random stimulus compared every cycle against a frame-level model.
module tb_arrow_menu_ctrl;
   localparam int N = 4, DEB = 3, BLINK = 30, BX = 200, BY = 150, STEP = 40;
   localparam int M_NAV = 10, M_CONF = 20, M_LOCK = 30;

   logic       clk = 1'b0, rst = 1'b1, frame_tick = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0, sel_ready = 1'b0;
   logic [9:0] pos_x, pos_y;
   logic       arrow_en, sel_valid;
   logic [1:0] index, sel_index;

   always #5 clk = ~clk;

   arrow_menu_ctrl #(.NUM_ITEMS(N), .BASE_X(10'd200), .BASE_Y(10'd150), .ROW_STEP(10'd40),
                     .DEB_FRAMES(DEB), .BLINK_FRAMES(BLINK)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
      .pos_x(pos_x), .pos_y(pos_y), .arrow_en(arrow_en), .index(index),
      .sel_valid(sel_valid), .sel_index(sel_index), .sel_ready(sel_ready)
   );

   int errors = 0, checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (frame-level rules) ----------------
   int m_held [3];          // consecutive high frame samples per button
   bit m_ev   [3];
   bit m_b    [3];
   int m_idx, m_sv, m_si, m_arrow, m_phase, m_mode;
   int hs_cnt = 0, hs_idx = -1;

   always @(posedge clk) begin
      m_b = '{btn_up, btn_down, btn_sel};
      if (rst) begin
         for (int k = 0; k < 3; k++) m_held[k] = 0;
         m_idx = 0; m_sv = 0; m_si = 0; m_arrow = 1; m_phase = 0; m_mode = M_NAV;
      end else begin
         if (sel_valid && sel_ready) begin
            hs_cnt++;
            hs_idx = sel_index;
         end
         for (int k = 0; k < 3; k++) begin
            m_ev[k] = 1'b0;
            if (frame_tick) begin
               if (m_b[k]) begin
                  m_held[k]++;
                  m_ev[k] = (m_held[k] == DEB);
               end else m_held[k] = 0;
            end
         end
         if (m_mode == M_NAV) begin
            if (m_ev[2]) begin
               m_si = m_idx; m_sv = 1; m_mode = M_CONF; m_phase = 0; m_arrow = 1;
            end else if (m_ev[0] != m_ev[1]) begin
               m_idx = (m_idx + (m_ev[1] ? 1 : N - 1)) % N;
               m_phase = 0; m_arrow = 1;
            end else if (frame_tick) begin
               m_phase++;
               if (m_phase == BLINK) begin
                  m_phase = 0; m_arrow = 1 - m_arrow;
               end
            end
         end else if (m_mode == M_CONF) begin
            if (m_sv == 1 && sel_ready) begin
               m_sv = 0; m_mode = M_LOCK;
            end
         end else begin
            if (frame_tick && m_held[0] == 0 && m_held[1] == 0 && m_held[2] == 0)
               m_mode = M_NAV;
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_index", int'(index), m_idx);
         chk("m_pos_x", int'(pos_x), BX);
         chk("m_pos_y", int'(pos_y), BY + m_idx * STEP);
         chk("m_arrow_en", int'(arrow_en), m_arrow);
         chk("m_sel_valid", int'(sel_valid), m_sv);
         if (m_sv == 1) chk("m_sel_index", int'(sel_index), m_si);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic frames(input int n, input bit u, input bit d, input bit s);
      btn_up = u; btn_down = d; btn_sel = s;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; frame_tick = 1'b0; sel_ready = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      bit up, down, sel;
      int n;
      int e_idx, e_y;
   } vec_t;
   vec_t tbl [13];

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      tbl[0]  = '{0, 1, 0, 2,  0, 150};   // two samples: not yet accepted
      tbl[1]  = '{0, 1, 0, 1,  1, 190};   // third sample accepts
      tbl[2]  = '{0, 1, 0, 10, 1, 190};   // holding: no auto-repeat
      tbl[3]  = '{0, 0, 0, 1,  1, 190};
      tbl[4]  = '{1, 0, 0, 3,  0, 150};
      tbl[5]  = '{0, 0, 0, 1,  0, 150};
      tbl[6]  = '{1, 0, 0, 3,  3, 270};   // 0 wraps to last row
      tbl[7]  = '{0, 0, 0, 1,  3, 270};
      tbl[8]  = '{0, 1, 0, 3,  0, 150};   // last row wraps to 0
      tbl[9]  = '{0, 0, 0, 1,  0, 150};
      tbl[10] = '{1, 1, 0, 3,  0, 150};   // up+down cancel
      tbl[11] = '{0, 0, 0, 1,  0, 150};
      tbl[12] = '{0, 1, 0, 4,  1, 190};

      // reset state
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_index", int'(index), 0);
      chk("rst_pos_x", int'(pos_x), 200);
      chk("rst_pos_y", int'(pos_y), 150);
      chk("rst_arrow_en", int'(arrow_en), 1);
      chk("rst_sel_valid", int'(sel_valid), 0);
      rst = 1'b0;

      // table-driven navigation
      foreach (tbl[i]) begin
         frames(tbl[i].n, tbl[i].up, tbl[i].down, tbl[i].sel);
         chk($sformatf("tbl%0d_index", i), int'(index), tbl[i].e_idx);
         chk($sformatf("tbl%0d_pos_y", i), int'(pos_y), tbl[i].e_y);
      end

      // up+down together must not restart the blink phase
      do_reset();
      frames(25, 0, 0, 0);
      frames(3, 1, 1, 0);
      chk("ud_index", int'(index), 0);
      chk("ud_arrow_t28", int'(arrow_en), 1);
      frames(1, 0, 0, 0);
      chk("ud_arrow_t29", int'(arrow_en), 1);
      frames(1, 0, 0, 0);
      chk("ud_arrow_t30", int'(arrow_en), 0);

      // idle blink: toggles at tick 30 and tick 60
      do_reset();
      frames(29, 0, 0, 0);
      chk("blink_t29", int'(arrow_en), 1);
      frames(1, 0, 0, 0);
      chk("blink_t30", int'(arrow_en), 0);
      frames(29, 0, 0, 0);
      chk("blink_t59", int'(arrow_en), 0);
      frames(1, 0, 0, 0);
      chk("blink_t60", int'(arrow_en), 1);

      // move at tick 45 forces arrow on and restarts the phase
      do_reset();
      frames(42, 0, 0, 0);
      chk("mv_arrow_t42", int'(arrow_en), 0);
      frames(3, 0, 1, 0);
      chk("mv_index_t45", int'(index), 1);
      chk("mv_arrow_t45", int'(arrow_en), 1);
      frames(29, 0, 0, 0);
      chk("mv_arrow_t74", int'(arrow_en), 1);
      frames(1, 0, 0, 0);
      chk("mv_arrow_t75", int'(arrow_en), 0);

      // select at index 2 with a stalled consumer, then lock
      do_reset();
      frames(3, 0, 1, 0); frames(1, 0, 0, 0);
      frames(3, 0, 1, 0); frames(1, 0, 0, 0);
      chk("sel_pre_index", int'(index), 2);
      frames(3, 0, 0, 1);
      chk("sel_valid_up", int'(sel_valid), 1);
      chk("sel_index_2", int'(sel_index), 2);
      hs0 = hs_cnt;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("sel_hold%0d_valid", c), int'(sel_valid), 1);
         chk($sformatf("sel_hold%0d_index", c), int'(sel_index), 2);
      end
      sel_ready = 1'b1;
      @(negedge clk);
      sel_ready = 1'b0;
      chk("sel_drop", int'(sel_valid), 0);
      chk("sel_hs_count", hs_cnt, hs0 + 1);
      chk("sel_hs_index", hs_idx, 2);
      frames(4, 0, 1, 1);
      chk("lock_ignore_down", int'(index), 2);
      chk("lock_no_reoffer", int'(sel_valid), 0);
      frames(1, 0, 0, 0);
      frames(3, 0, 1, 0);
      chk("unlock_down", int'(index), 3);
      frames(1, 0, 0, 0);

      // reset during an in-flight offer
      do_reset();
      frames(3, 0, 1, 0); frames(1, 0, 0, 0);
      frames(3, 0, 0, 1);
      chk("rsel_valid", int'(sel_valid), 1);
      chk("rsel_index", int'(sel_index), 1);
      btn_sel = 1'b0;
      hs0 = hs_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rsel_valid_cleared", int'(sel_valid), 0);
      chk("rsel_index0", int'(index), 0);
      chk("rsel_pos_y", int'(pos_y), 150);
      sel_ready = 1'b1;
      repeat (3) @(negedge clk);
      sel_ready = 1'b0;
      chk("rsel_no_hs", hs_cnt, hs0);
      chk("rsel_ready_noeffect", int'(sel_valid), 0);

      // random stimulus against the model
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         frame_tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 11) == 0) btn_up   = ~btn_up;
         if ($urandom_range(0, 11) == 0) btn_down = ~btn_down;
         if ($urandom_range(0, 15) == 0) btn_sel  = ~btn_sel;
         sel_ready = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 499) == 0);
         @(negedge clk);
      end
      rst = 1'b0; frame_tick = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
